// File: rtl/reg_writeback_unit.sv
// +--------------------------------------------------------------------------+
// | reg_writeback_unit: merges ALU and buffered load results onto the single |
// | register-file write port and tracks per-register pending writes.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_writeback_unit #(
  parameter int DATA_W   = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [2:0]        issue_rd,
  input  logic [2:0]        issue_rs1,
  input  logic [2:0]        issue_rs2,
  output logic              stall,
  input  logic              alu_valid,
  input  logic [2:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_value,
  output logic              alu_ready,
  input  logic              load_valid,
  input  logic [2:0]        load_rd,
  input  logic [DATA_W-1:0] load_value,
  output logic              load_ready,
  output logic              reg_write_en,
  output logic [2:0]        rd,
  output logic [DATA_W-1:0] rd_value,
  output logic [7:0]        pending
);

  logic [2:0]        r_lq_rd  [LQ_DEPTH];
  logic [DATA_W-1:0] r_lq_val [LQ_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              r_wen;
  logic [2:0]        r_rd;
  logic [DATA_W-1:0] r_value;
  logic [7:0]        r_pending;

  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  logic              w_sel_alu;
  logic              w_sel_fifo;
  logic [2:0]        w_sel_rd;
  logic [DATA_W-1:0] w_sel_value;
  logic [7:0]        w_set;
  logic [7:0]        w_clr;
  logic [7:0]        w_pending_nxt;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);

  // Readiness depends on registered occupancy only, so a full FIFO never
  // accepts a load even in a cycle where it is also dequeuing.
  assign load_ready = !w_full;
  assign alu_ready  = !w_full;
  assign w_enq      = load_valid && !w_full;

  always_comb begin
    w_sel_alu   = 1'b0;
    w_sel_fifo  = 1'b0;
    w_sel_rd    = 3'd0;
    w_sel_value = '0;
    if (w_full) begin
      w_sel_fifo = 1'b1;
    end else if (alu_valid) begin
      w_sel_alu = 1'b1;
    end else if (!w_empty) begin
      w_sel_fifo = 1'b1;
    end
    if (w_sel_alu) begin
      w_sel_rd    = alu_rd;
      w_sel_value = alu_value;
    end else if (w_sel_fifo) begin
      w_sel_rd    = r_lq_rd[r_rd_ptr];
      w_sel_value = r_lq_val[r_rd_ptr];
    end
  end

  assign w_deq = w_sel_fifo;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_lq_rd[r_wr_ptr]  <= load_rd;
      r_lq_val[r_wr_ptr] <= load_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Results targeting x0 are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_rd    <= 3'd0;
      r_value <= '0;
    end else begin
      r_wen   <= (w_sel_alu || w_sel_fifo) && (w_sel_rd != 3'd0);
      r_rd    <= w_sel_rd;
      r_value <= w_sel_value;
    end
  end

  assign stall = r_pending[issue_rs1] | r_pending[issue_rs2] |
                 r_pending[issue_rd]  | w_full;

  always_comb begin
    w_set = 8'h00;
    w_clr = 8'h00;
    if (issue_valid && !stall && (issue_rd != 3'd0)) begin
      w_set = 8'h01 << issue_rd;
    end
    if (r_wen) begin
      w_clr = 8'h01 << r_rd;
    end
    // Set is applied after clear so it wins on a collision.
    w_pending_nxt = ((r_pending & ~w_clr) | w_set) & 8'hFE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 8'h00;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign reg_write_en = r_wen;
  assign rd           = r_rd;
  assign rd_value     = r_value;
  assign pending      = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
// Testbench for reg_writeback_unit: vector table plus directed sequences,
// with register-file writes checked against an expected-write queue.
`default_nettype none

module tb_reg_writeback_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_rs1;
  logic [2:0]  issue_rs2;
  logic        stall;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        load_valid;
  logic [2:0]  load_rd;
  logic [31:0] load_value;
  logic        load_ready;
  logic        reg_write_en;
  logic [2:0]  rd;
  logic [31:0] rd_value;
  logic [7:0]  pending;

  reg_writeback_unit #(.DATA_W(32), .LQ_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .stall        (stall),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_value    (alu_value),
    .alu_ready    (alu_ready),
    .load_valid   (load_valid),
    .load_rd      (load_rd),
    .load_value   (load_value),
    .load_ready   (load_ready),
    .reg_write_en (reg_write_en),
    .rd           (rd),
    .rd_value     (rd_value),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] val;
    logic [7:0]  exp_pend;
  } alu_vec_t;
  alu_vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] r, input logic [31:0] v);
    exp_q.push_back({r, v});
  endtask

  always @(negedge clk) begin
    if (rst_n && reg_write_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got rd=%0d val=%h, required no write", rd, rd_value);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({rd, rd_value} !== e) begin
          n_fail++;
          $display("FAIL wr_data: got rd=%0d val=%h, required rd=%0d val=%h",
                   rd, rd_value, e[34:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{rd: 3'd1, val: 32'hA5A5_0001, exp_pend: 8'h02};
    vecs[1] = '{rd: 3'd7, val: 32'h7777_0000, exp_pend: 8'h80};
    vecs[2] = '{rd: 3'd0, val: 32'h0000_FFFF, exp_pend: 8'h00};
    vecs[3] = '{rd: 3'd4, val: 32'h0000_0004, exp_pend: 8'h10};
    vecs[4] = '{rd: 3'd2, val: 32'hFFFF_FFFF, exp_pend: 8'h04};
    vecs[5] = '{rd: 3'd6, val: 32'h0000_0000, exp_pend: 8'h40};

    rst_n = 1'b1;
    issue_valid = 1'b0; issue_rd = 3'd0; issue_rs1 = 3'd0; issue_rs2 = 3'd0;
    alu_valid = 1'b0; alu_rd = 3'd0; alu_value = 32'd0;
    load_valid = 1'b0; load_rd = 3'd0; load_value = 32'd0;

    // Power-on reset, observed before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_wen", reg_write_en, 1'b0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ALU path with RAW stall on rs1.
    issue_valid = 1'b1; issue_rd = 3'd3;
    #1 chk("alu_issue_stall", stall, 1'b0);
    tick();
    chk("alu_pend3_set", pending, 8'h08);
    issue_valid = 1'b1; issue_rd = 3'd4; issue_rs1 = 3'd3;
    alu_valid = 1'b1; alu_rd = 3'd3; alu_value = 32'h0000_1234;
    push(3'd3, 32'h0000_1234);
    #1 chk("alu_raw_stall_n", stall, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk("alu_wen_n1", reg_write_en, 1'b1);
    chk("alu_pend3_n1", pending, 8'h08);
    chk("alu_raw_stall_n1", stall, 1'b1);
    tick();
    chk("alu_pend3_clr", pending, 8'h00);
    chk("alu_raw_released", stall, 1'b0);
    tick();
    issue_valid = 1'b0; issue_rd = 3'd0; issue_rs1 = 3'd0;
    chk("alu_pend4_set", pending, 8'h10);
    alu_valid = 1'b1; alu_rd = 3'd4; alu_value = 32'h0000_4444;
    push(3'd4, 32'h0000_4444);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("alu_pend4_clr", pending, 8'h00);

    // Table of issue-then-ALU-write transactions.
    foreach (vecs[i]) begin
      if (vecs[i].rd != 3'd0) begin
        issue_valid = 1'b1; issue_rd = vecs[i].rd;
        #1 chk("vec_issue_stall", stall, 1'b0);
        tick();
        issue_valid = 1'b0; issue_rd = 3'd0;
      end
      chk("vec_pend_set", pending, vecs[i].exp_pend);
      alu_valid = 1'b1; alu_rd = vecs[i].rd; alu_value = vecs[i].val;
      if (vecs[i].rd != 3'd0) push(vecs[i].rd, vecs[i].val);
      #1 chk("vec_alu_ready", alu_ready, 1'b1);
      tick();
      alu_valid = 1'b0;
      chk("vec_wen", reg_write_en, vecs[i].rd != 3'd0);
      chk("vec_pend_hold", pending, vecs[i].exp_pend);
      tick();
      chk("vec_pend_clr", pending, 8'h00);
    end

    // Contention: ALU wins, load waits until the ALU goes idle.
    alu_valid = 1'b1; alu_rd = 3'd6; alu_value = 32'h1;
    load_valid = 1'b1; load_rd = 3'd5; load_value = 32'hDEAD_BEEF;
    push(3'd6, 32'h1);
    #1 chk("cont_load_ready", load_ready, 1'b1);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alu_rd = 3'd1; alu_value = 32'h10 + k;
      push(3'd1, 32'h10 + k);
      #1 chk("cont_alu_ready", alu_ready, 1'b1);
      tick();
    end
    alu_valid = 1'b0;
    push(3'd5, 32'hDEAD_BEEF);
    tick();
    chk("cont_load_wen", reg_write_en, 1'b1);
    tick();

    // FIFO full with continuous ALU traffic.
    alu_valid = 1'b1; alu_rd = 3'd1; alu_value = 32'h100;
    load_valid = 1'b1; load_rd = 3'd3; load_value = 32'h3333;
    push(3'd1, 32'h100);
    tick();
    alu_value = 32'h101; load_rd = 3'd4; load_value = 32'h4444;
    push(3'd1, 32'h101);
    #1 chk("full_ready_c1", load_ready, 1'b1);
    tick();
    alu_value = 32'h102; load_rd = 3'd5; load_value = 32'h5555;
    push(3'd3, 32'h3333);
    #1;
    chk("full_load_ready", load_ready, 1'b0);
    chk("full_alu_ready", alu_ready, 1'b0);
    chk("full_stall", stall, 1'b1);
    tick();
    push(3'd1, 32'h102);
    #1;
    chk("full_l3_ready", load_ready, 1'b1);
    chk("full_alu_ready_back", alu_ready, 1'b1);
    tick();
    load_valid = 1'b0; alu_value = 32'h103;
    push(3'd4, 32'h4444);
    #1 chk("full_again_alu_ready", alu_ready, 1'b0);
    tick();
    push(3'd1, 32'h103);
    tick();
    alu_valid = 1'b0;
    push(3'd5, 32'h5555);
    tick();
    tick();
    tick();

    // Load to x0 is consumed without a write.
    load_valid = 1'b1; load_rd = 3'd0; load_value = 32'hFFFF;
    tick();
    load_valid = 1'b0;
    tick();
    chk("x0_load_wen", reg_write_en, 1'b0);
    chk("x0_pending", pending, 8'h00);
    chk("x0_drained", alu_ready && load_ready, 1'b1);

    // WAW on x2 behind a load.
    issue_valid = 1'b1; issue_rd = 3'd2;
    tick();
    load_valid = 1'b1; load_rd = 3'd2; load_value = 32'h2222_0002;
    push(3'd2, 32'h2222_0002);
    #1 chk("waw_stall_b", stall, 1'b1);
    tick();
    load_valid = 1'b0;
    chk("waw_stall_c", stall, 1'b1);
    tick();
    chk("waw_wen_d", reg_write_en, 1'b1);
    chk("waw_stall_d", stall, 1'b1);
    tick();
    chk("waw_stall_e", stall, 1'b0);
    tick();
    issue_valid = 1'b0; issue_rd = 3'd0;
    chk("waw_pend_reset", pending, 8'h04);
    alu_valid = 1'b1; alu_rd = 3'd2; alu_value = 32'h2;
    push(3'd2, 32'h2);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("waw_pend_clr", pending, 8'h00);

    // Asynchronous reset while the FIFO holds two entries.
    alu_valid = 1'b1; alu_rd = 3'd1; alu_value = 32'h200;
    load_valid = 1'b1; load_rd = 3'd4; load_value = 32'h44;
    issue_valid = 1'b1; issue_rd = 3'd7;
    push(3'd1, 32'h200);
    tick();
    issue_valid = 1'b0; issue_rd = 3'd0;
    alu_value = 32'h201; load_rd = 3'd5; load_value = 32'h55;
    tick();
    alu_valid = 1'b0; load_valid = 1'b0;
    chk("mr_full", load_ready, 1'b0);
    chk("mr_pend7", pending, 8'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_wen", reg_write_en, 1'b0);
    chk("mr_rd", rd, 3'd0);
    chk("mr_value", rd_value, 32'd0);
    chk("mr_pending", pending, 8'h00);
    chk("mr_load_ready", load_ready, 1'b1);
    chk("mr_alu_ready", alu_ready, 1'b1);
    chk("mr_stall", stall, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("mr_no_write", reg_write_en, 1'b0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_all_written", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
